board_io_ctrl: RTL and testbench
================================

# board_io_ctrl

Board-side companion to the pipeline top. It turns a bouncy push-button into a clean single-step clock for the pipeline and drives a 4-digit multiplexed seven-segment display with either the pipeline's PC or the selected register value. It sits between the board pins and the pipeline: upstream of its `clock` input and downstream of its `pc_out`/`register_out` outputs.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 1000000: consecutive stable cycles required before the debounced level changes; must be ≥ 2.
- REFRESH_BITS, 18: width of the display scan counter; its top 2 bits select the active digit; must be ≥ 3.

Ports:
- clock  in  1  board oscillator clock; the only clock in the block.
- reset  in  1  asynchronous, active-high reset.
- step_button  in  1  raw push-button, asynchronous to `clock`, active-high.
- show_pc  in  1  1 = display `pc_in`, 0 = display `reg_in`.
- half_sel  in  1  1 = upper 16 bits, 0 = lower 16 bits; effective only with the macro (see Configuration).
- pc_in  in  32  pipeline `pc_out`.
- reg_in  in  32  pipeline `register_out`.
- step_clock  out  1  debounced button level; drives the pipeline `clock`.
- step_pulse  out  1  one-`clock` pulse on each debounced rising edge.
- anode  out  4  digit enables, active-low; bit 0 is the rightmost digit.
- cathode  out  7  segments {g,f,e,d,c,b,a}, active-low.

## Operation
- Synchroniser: 2-flop chain on `step_button`; only the second flop's output is used.
- Debouncer: counter clears whenever the synchronised input equals the current debounced level. Otherwise it increments. When it reaches DEBOUNCE_CYCLES−1 while still differing, the debounced level toggles and the counter clears. A glitch shorter than DEBOUNCE_CYCLES never reaches `step_clock`.
- `step_clock` is the registered debounced level. `step_pulse` = debounced level AND NOT previous debounced level, registered.
- Source select: sel32 = show_pc ? pc_in : reg_in. sel16 = half_sel ? sel32[31:16] : sel32[15:0].
- Snapshot: a 16-bit `shown` register loads sel16 only on the cycle the scan counter wraps from all-ones to 0. This prevents tearing mid-scan.
- Scan: free-running REFRESH_BITS counter. Digit index d = counter[MSB:MSB−1]. `anode` = ~(1<<d). The displayed nibble is shown[4d+3:4d].
- Hex encoding, fixed: 0→1000000, 1→1111001, 2→0100100, 3→0110000, 4→0011001, 5→0010010, 6→0000010, 7→1111000, 8→0000000, 9→0010000, A→0001000, b→0000011, C→1000110, d→0100001, E→0000110, F→0001110.

## Timing
- Reset values: step_clock 0, step_pulse 0, anode 4'b1110, cathode 7'b1000000, `shown` 0, all counters and synchroniser flops 0.
- Button-to-step latency: 2 synchroniser cycles + DEBOUNCE_CYCLES + 1 output register cycle. `step_pulse` rises in the same cycle as `step_clock`.
- Release follows the same latency. Each press produces exactly one `step_pulse`.
- `anode` and `cathode` are registered and change together, one cycle after the counter changes digit.
- A new sel16 appears on the display no earlier than the next wrap and no later than 2^REFRESH_BITS + 1 cycles after it changes.
- Simultaneous wrap and input change: the value sampled in the wrap cycle is the one captured.
- Reset mid-debounce or mid-scan: everything returns to reset values immediately. A button still held when reset is released is seen as a new press after the full latency.

## Configuration
- BOARD_IO_HALF_SEL_EN defined: `half_sel` chooses the upper or lower 16 bits as described.
- Not defined: `half_sel` is ignored (port kept) and sel16 = sel32[15:0] always.

## Structure
- Package `board_io_pkg`: the 16-entry seven-segment constant table or function, the active-low blank constant 7'b1111111, and the digit-count constant 4.
- One sub-module `button_debounce` holds the synchroniser, stability counter and debounced level. It is parameterised by DEBOUNCE_CYCLES and outputs `level` and `rise`.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and REFRESH_BITS=4.
- Reset asserted mid-run → anode=1110, cathode=1000000, step_clock=0 during reset and on the first cycle after release.
- Clean press held 20 cycles → step_clock rises 7 cycles after the press, step_pulse high for exactly 1 cycle; release → step_clock falls 7 cycles later.
- Bounce: 3-cycle pulses separated by 2-cycle gaps, then held → exactly one step_pulse, and no change in step_clock during the bounce.
- show_pc=1, pc_in=0x0040_1A3F, half_sel=0 → after the next wrap the digits d0..d3 show F,3,A,1: cathode 0001110, 0110000, 0001000, 1111001 with anode 1110, 1101, 1011, 0111.
- Macro on, half_sel=1, show_pc=0, reg_in=0xBEEF_0000 → digits show F,E,E,b. Macro off, same stimulus → all four digits show 0 (1000000).
- pc_in changed from 0x1234 to 0x5678 mid-scan → the remaining digits of the current scan still show 1234; the next scan shows 5678.

Source files
------------

// File: rtl/board_io_pkg.sv
// Shared constants for the board I/O companion: seven-segment encoding and display geometry.
package board_io_pkg;

  localparam int unsigned NumDigits = 4;
  localparam logic [6:0]  SegBlank  = 7'b1111111;

  // Segment order is {g,f,e,d,c,b,a}, active-low.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'ha:    seg = 7'b0001000;
      4'hb:    seg = 7'b0000011;
      4'hc:    seg = 7'b1000110;
      4'hd:    seg = 7'b0100001;
      4'he:    seg = 7'b0000110;
      4'hf:    seg = 7'b0001110;
      default: seg = SegBlank;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Push-button synchroniser and stability-counter debouncer with registered level and rising pulse.
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clock,
  input  logic reset,
  input  logic button,
  output logic level,
  output logic rise
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic            sync1_q, sync2_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            deb_q, deb_d;
  logic            level_q, rise_q;

  // Counter only runs while the synchronised input disagrees with the debounced level.
  always_comb begin
    cnt_d = '0;
    deb_d = deb_q;
    if (sync2_q != deb_q) begin
      if (cnt_q == CntMax) begin
        deb_d = ~deb_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      deb_q   <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync1_q <= button;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      deb_q   <= deb_d;
      level_q <= deb_q;
      rise_q  <= deb_q & ~level_q;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule

// File: rtl/board_io_ctrl.sv
// Board companion: debounced single-step clock and 4-digit hex display of PC or register value.
// Optional macro BOARD_IO_HALF_SEL_EN lets half_sel pick the upper 16 bits for display.
module board_io_ctrl
  import board_io_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REFRESH_BITS    = 18
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 step_button,
  input  logic                 show_pc,
  input  logic                 half_sel,
  input  logic [31:0]          pc_in,
  input  logic [31:0]          reg_in,
  output logic                 step_clock,
  output logic                 step_pulse,
  output logic [NumDigits-1:0] anode,
  output logic [6:0]           cathode
);

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clock (clock),
    .reset (reset),
    .button(step_button),
    .level (step_clock),
    .rise  (step_pulse)
  );

  logic [31:0] sel32;
  logic [15:0] sel16;

  assign sel32 = show_pc ? pc_in : reg_in;

`ifdef BOARD_IO_HALF_SEL_EN
  assign sel16 = half_sel ? sel32[31:16] : sel32[15:0];
`else
  logic unused_half;
  assign sel16       = sel32[15:0];
  assign unused_half = ^{half_sel, sel32[31:16]};
`endif

  logic [REFRESH_BITS-1:0] scan_q;
  logic [15:0]             shown_q, shown_d;
  logic [1:0]              digit;
  logic [3:0]              nibble;
  logic [NumDigits-1:0]    anode_q, anode_d;
  logic [6:0]              cathode_q, cathode_d;

  // Snapshot only at scan wrap so a full scan always shows one coherent value.
  always_comb begin
    shown_d   = shown_q;
    if (&scan_q) begin
      shown_d = sel16;
    end
    digit     = scan_q[REFRESH_BITS-1 -: 2];
    nibble    = shown_q[{digit, 2'b00} +: 4];
    anode_d   = ~(NumDigits'(1) << digit);
    cathode_d = hex_to_seg(nibble);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      scan_q    <= '0;
      shown_q   <= '0;
      anode_q   <= 4'b1110;
      cathode_q <= 7'b1000000;
    end else begin
      scan_q    <= scan_q + 1'b1;
      shown_q   <= shown_d;
      anode_q   <= anode_d;
      cathode_q <= cathode_d;
    end
  end

  assign anode   = anode_q;
  assign cathode = cathode_q;

endmodule

// File: tb/tb_board_io_ctrl.sv
// Scoreboard bench for board_io_ctrl with a cycle-count reference model of debounce and display.
module tb_board_io_ctrl;

  localparam int Deb     = 4;
  localparam int RBits   = 4;
  localparam int ScanLen = 1 << RBits;
  localparam int DigLen  = ScanLen / 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        step_button = 1'b0;
  logic        show_pc = 1'b0;
  logic        half_sel = 1'b0;
  logic [31:0] pc_in = '0;
  logic [31:0] reg_in = '0;
  logic        step_clock, step_pulse;
  logic [3:0]  anode;
  logic [6:0]  cathode;

  typedef struct packed {
    logic       sc;
    logic       sp;
    logic [3:0] an;
    logic [6:0] ca;
  } exp_t;

  exp_t       exp_q[$];
  int         total = 0;
  int         bad = 0;
  logic [6:0] seg_ref[16];

  board_io_ctrl #(
    .DEBOUNCE_CYCLES(Deb),
    .REFRESH_BITS   (RBits)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .step_button(step_button),
    .show_pc    (show_pc),
    .half_sel   (half_sel),
    .pc_in      (pc_in),
    .reg_in     (reg_in),
    .step_clock (step_clock),
    .step_pulse (step_pulse),
    .anode      (anode),
    .cathode    (cathode)
  );

  always #5 clock = ~clock;

  function automatic logic [15:0] ref_sel16();
    logic [31:0] w;
    w = show_pc ? pc_in : reg_in;
`ifdef BOARD_IO_HALF_SEL_EN
    return half_sel ? w[31:16] : w[15:0];
`else
    return w[15:0];
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
    end
  endtask

  // Reference model: level flips once the button (seen two cycles late) has disagreed with it
  // for Deb consecutive samples; display shows the value latched every ScanLen cycles.
  initial begin : model
    int          e;
    bit          lvl, lvl_prev, s, all_diff;
    bit          b_hist[$];
    bit          s_win[$];
    logic [15:0] shown_m;
    int          dig;
    exp_t        x;
    seg_ref = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    e = 0; lvl = 0; lvl_prev = 0; shown_m = '0;
    forever begin
      @(posedge clock);
      if (reset) begin
        e = 0; lvl = 0; lvl_prev = 0; shown_m = '0;
        b_hist.delete();
        s_win.delete();
        x = '{sc: 1'b0, sp: 1'b0, an: 4'b1110, ca: 7'b1000000};
        exp_q.push_back(x);
      end else begin
        e++;
        dig  = ((e - 1) % ScanLen) / DigLen;
        x.sc = lvl;
        x.sp = lvl & ~lvl_prev;
        x.an = ~(4'b0001 << dig);
        x.ca = seg_ref[shown_m[dig*4 +: 4]];
        exp_q.push_back(x);
        s = (b_hist.size() >= 2) ? b_hist[b_hist.size() - 2] : 1'b0;
        s_win.push_back(s);
        if (s_win.size() > Deb) void'(s_win.pop_front());
        all_diff = (s_win.size() == Deb);
        foreach (s_win[i]) if (s_win[i] == lvl) all_diff = 0;
        lvl_prev = lvl;
        if (all_diff) lvl = ~lvl;
        b_hist.push_back(step_button);
        if (b_hist.size() > 2) void'(b_hist.pop_front());
        if (e % ScanLen == 0) shown_m = ref_sel16();
      end
    end
  end

  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        check("step_clock", 32'(step_clock), 32'(x.sc));
        check("step_pulse", 32'(step_pulse), 32'(x.sp));
        check("anode", 32'(anode), 32'(x.an));
        check("cathode", 32'(cathode), 32'(x.ca));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clock);
      #1;
    end
  endtask

  initial begin : driver
    tick(3);
    reset = 0;
    tick(5);
    // Clean press and release
    step_button = 1; tick(20);
    step_button = 0; tick(20);
    // Bouncing press then a solid hold
    repeat (3) begin
      step_button = 1; tick(3);
      step_button = 0; tick(2);
    end
    step_button = 1; tick(15);
    step_button = 0; tick(15);
    // Display PC low half
    show_pc = 1; half_sel = 0; pc_in = 32'h0040_1A3F; tick(40);
    // Register upper half (lower half without the macro)
    show_pc = 0; half_sel = 1; reg_in = 32'hBEEF_0000; tick(40);
    // Value change mid-scan
    show_pc = 1; half_sel = 0; pc_in = 32'h0000_1234; tick(22);
    pc_in = 32'h0000_5678; tick(40);
    // Reset mid-run with the button held through release
    step_button = 1; tick(3);
    reset = 1; tick(2);
    reset = 0; tick(15);
    step_button = 0; tick(10);
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 5) == 0) step_button = ~step_button;
      if ($urandom_range(0, 7) == 0) pc_in = $urandom;
      if ($urandom_range(0, 7) == 0) reg_in = $urandom;
      if ($urandom_range(0, 19) == 0) show_pc = ~show_pc;
      if ($urandom_range(0, 19) == 0) half_sel = ~half_sel;
      reset = ($urandom_range(0, 599) == 0);
      tick(1);
    end
    reset = 0;
    tick(3);
    total++;
    if (exp_q.size() > 1) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected at most 1", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
